// File: rtl/step_dir_microstep_writer.sv
// Purpose : per-line STEP/DIR -> 7-bit electrical phase -> scaled sin/cos coil words,
//           written out one line at a time on the we/regIndex/regData register bus.
// Latency : edge sampled at clk k -> we=1 after clk k+2 (+2 with STEP_SYNC_EN); 3 clks per write.
// Backpr. : none; steps arriving while a line is pending coalesce, phase stays exact.
// Ports   : clk, nRst (sync active-low); step/dir per line; scale (global current);
//           we/regIndex/regData write bus; busy = any line dirty or FSM not idle.
// Config  : STEP_SYNC_EN adds 2-FF synchronizers on step and dir.
module step_dir_microstep_writer #(
    parameter int LINES_NUM = 16,
    parameter int SCALE_W   = 7
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [LINES_NUM-1:0] step,
    input  logic [LINES_NUM-1:0] dir,
    input  logic [SCALE_W-1:0]   scale,
    output logic                 we,
    output logic [15:0]          regIndex,
    output logic [15:0]          regData,
    output logic                 busy
);
    localparam int LW = (LINES_NUM > 1) ? $clog2(LINES_NUM) : 1;

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t               state, state_nxt;
    logic [LINES_NUM-1:0] step_s, dir_s, step_prev, edge_v;
    logic [LINES_NUM-1:0] dirty, set_mask, clr_mask;
    logic [6:0]           phase [LINES_NUM];
    logic [SCALE_W-1:0]   scale_q;
    logic                 scale_chg;
    logic [LW-1:0]        ptr, cur, sel;
    logic                 found;
    int                   idx;
    logic [6:0]           cur_phase;
    logic [15:0]          word;

`ifdef STEP_SYNC_EN
    logic [LINES_NUM-1:0] step_m, dir_m;
    // Both signals share the same two-stage delay so dir stays aligned with its step.
    always_ff @(posedge clk) begin
        step_m <= step;
        step_s <= step_m;
        dir_m  <= dir;
        dir_s  <= dir_m;
    end
`else
    assign step_s = step;
    assign dir_s  = dir;
`endif

    // Quarter-wave table: round(127*sin(i*pi/64)), i = 0..32.
    function automatic logic [6:0] sin_tab(input logic [5:0] i);
        case (i)
            6'd0:  sin_tab = 7'd0;   6'd1:  sin_tab = 7'd6;   6'd2:  sin_tab = 7'd12;
            6'd3:  sin_tab = 7'd19;  6'd4:  sin_tab = 7'd25;  6'd5:  sin_tab = 7'd31;
            6'd6:  sin_tab = 7'd37;  6'd7:  sin_tab = 7'd43;  6'd8:  sin_tab = 7'd49;
            6'd9:  sin_tab = 7'd54;  6'd10: sin_tab = 7'd60;  6'd11: sin_tab = 7'd65;
            6'd12: sin_tab = 7'd71;  6'd13: sin_tab = 7'd76;  6'd14: sin_tab = 7'd81;
            6'd15: sin_tab = 7'd85;  6'd16: sin_tab = 7'd90;  6'd17: sin_tab = 7'd94;
            6'd18: sin_tab = 7'd98;  6'd19: sin_tab = 7'd102; 6'd20: sin_tab = 7'd106;
            6'd21: sin_tab = 7'd109; 6'd22: sin_tab = 7'd112; 6'd23: sin_tab = 7'd115;
            6'd24: sin_tab = 7'd117; 6'd25: sin_tab = 7'd120; 6'd26: sin_tab = 7'd122;
            6'd27: sin_tab = 7'd123; 6'd28: sin_tab = 7'd125; 6'd29: sin_tab = 7'd126;
            6'd30: sin_tab = 7'd126; 6'd31: sin_tab = 7'd127; 6'd32: sin_tab = 7'd127;
            default: sin_tab = 7'd0;
        endcase
    endfunction

    // One coil byte {sign, mag}: odd quadrants mirror the table, upper half is negative.
    // A zero magnitude from the table counts as positive (sign bit set).
    function automatic logic [7:0] coil_byte(input logic [6:0] p, input logic [SCALE_W-1:0] s);
        logic [5:0]         ti;
        logic [6:0]         t;
        logic [SCALE_W:0]   s1;
        logic [SCALE_W+7:0] prod;
        logic [6:0]         mag;
        ti   = p[5] ? (6'd32 - {1'b0, p[4:0]}) : {1'b0, p[4:0]};
        t    = sin_tab(ti);
        s1   = {1'b0, s} + 1'b1;
        prod = {{(SCALE_W+1){1'b0}}, t} * {7'd0, s1};
        mag  = 7'(prod >> 7);
        return {~(p[6] && (t != 7'd0)), mag};
    endfunction

    assign edge_v    = step_s & ~step_prev;
    assign scale_chg = (scale != scale_q);
    assign set_mask  = edge_v | {LINES_NUM{scale_chg}};
    assign cur_phase = phase[cur];
    assign word      = {coil_byte(cur_phase + 7'd32, scale_q), coil_byte(cur_phase, scale_q)};
    assign we        = (state == WRITE);
    assign busy      = (|dirty) || (state != IDLE);

    // Round-robin pick of the first dirty line starting at ptr.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        idx      = 0;
        clr_mask = '0;
        for (int i = 0; i < LINES_NUM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= LINES_NUM) idx = idx - LINES_NUM;
            if (!found && dirty[idx]) begin
                found = 1'b1;
                sel   = LW'(idx);
            end
        end
        if (state == IDLE && found) clr_mask[sel] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            // Previous-value registers load the live inputs so a held step or a
            // static scale does not look like a change right after reset.
            step_prev <= step_s;
            scale_q   <= scale;
            dirty     <= '1;
            ptr       <= '0;
            cur       <= '0;
            regIndex  <= '0;
            regData   <= '0;
            for (int i = 0; i < LINES_NUM; i++) phase[i] <= '0;
        end else begin
            step_prev <= step_s;
            scale_q   <= scale;
            for (int i = 0; i < LINES_NUM; i++) begin
                if (edge_v[i]) phase[i] <= phase[i] + (dir_s[i] ? 7'd1 : 7'd127);
            end
            // A new set on the line being picked wins over its clear.
            dirty <= (dirty & ~clr_mask) | set_mask;
            if (state == IDLE && found) cur <= sel;
            if (state == CALC) begin
                regData  <= word;
                regIndex <= 16'({cur, 1'b0});
            end
            if (state == WRITE) ptr <= (cur == LW'(LINES_NUM - 1)) ? '0 : cur + 1'b1;
        end
    end
endmodule

// File: tb/tb_step_dir_microstep_writer.sv
// Purpose : directed self-checking bench for step_dir_microstep_writer.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_step_dir_microstep_writer;
    localparam int N = 16;
`ifdef STEP_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic         clk = 1'b0;
    logic         nRst;
    logic [N-1:0] step, dir;
    logic [6:0]   scale;
    logic         we, busy;
    logic [15:0]  regIndex, regData;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] wq[$];
    int          wc[$];

    step_dir_microstep_writer #(.LINES_NUM(N), .SCALE_W(7)) dut (
        .clk(clk), .nRst(nRst), .step(step), .dir(dir), .scale(scale),
        .we(we), .regIndex(regIndex), .regData(regData), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write capture: {regIndex, regData} and the cycle it was seen.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wq.push_back({regIndex, regData});
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wget(input int i);
        if (i < wq.size()) return wq[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic pulse(input int line, input logic d);
        @(negedge clk);
        dir[line]  = d;
        step[line] = 1'b1;
        @(negedge clk);
        step[line] = 1'b0;
    endtask

    // Checks that the queue holds 16 writes, in line order from 0, all with data d.
    task automatic chk_sweep(input string tag, input logic [15:0] d);
        int bad;
        bad = 0;
        chk({tag, "_count"}, 32'(wq.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            if (wget(i) !== {16'(2 * i), d}) bad++;
        chk({tag, "_bad_entries"}, 32'(bad), 32'd0);
        chk({tag, "_first"}, wget(0), {16'd0, d});
        chk({tag, "_last"}, wget(15), {16'd30, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        nRst  = 1'b0;
        step  = '0;
        dir   = '0;
        scale = 7'd127;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_idx", 32'(regIndex), 32'd0);
        chk("rst_data", 32'(regData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Post-reset sweep of all lines at full scale, one write every 3 cycles.
        wq.delete(); wc.delete();
        nRst = 1'b1;
        wait_idle(200);
        chk_sweep("init", 16'hFF80);
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (i < wc.size() && (wc[i] - wc[i-1]) != 3) bad++;
        chk("init_spacing", 32'(bad), 32'd0);

        // Line 3 single step up: exact latency and data.
        @(negedge clk);
        wq.delete();
        dir[3]  = 1'b1;
        step[3] = 1'b1;
        repeat (2 + EXTRA) begin
            @(negedge clk);
            chk("lat_we_early", 32'(we), 32'd0);
        end
        @(negedge clk);
        chk("lat_we", 32'(we), 32'd1);
        chk("lat_idx", 32'(regIndex), 32'd6);
        chk("lat_data", 32'(regData), 32'hFF86);
        step[3] = 1'b0;
        wait_idle(50);
        chk("lat_count", 32'(wq.size()), 32'd1);

        // Line 0 step down from phase 0 wraps to 127.
        wq.delete();
        pulse(0, 1'b0);
        wait_idle(50);
        chk("wrap_count", 32'(wq.size()), 32'd1);
        chk("wrap_write", wget(0), {16'd0, 16'hFF06});

        // Line 5: 32 spaced steps up -> phase 32.
        wq.delete();
        for (int i = 0; i < 32; i++) begin
            pulse(5, 1'b1);
            @(negedge clk);
        end
        wait_idle(100);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i][31:16] !== 16'd10) bad++;
        chk("l5_other_idx", 32'(bad), 32'd0);
        chk("l5_last", wget(wq.size() - 1), {16'd10, 16'h80FF});

        // Reset in the middle of the post-reset sweep aborts the write.
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        n = 0;
        while (we !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_we_seen", 32'(we), 32'd1);
        nRst = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_idx", 32'(regIndex), 32'd0);
        chk("mid_rst_data", 32'(regData), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        wq.delete();
        nRst = 1'b1;
        wait_idle(200);
        chk_sweep("after_rst", 16'hFF80);

        // Scale 127 -> 63 with all phases 0: full rewrite at half current.
        @(negedge clk);
        wq.delete();
        scale = 7'd63;
        wait_idle(200);
        chk_sweep("scale63", 16'hBF80);

        // Lines 0,1 pending while line 2 takes 4 steps: one coalesced line-2 write.
        @(negedge clk);
        wq.delete();
        dir[2:0]  = 3'b111;
        step[2:0] = 3'b111;
        @(negedge clk);
        step[2:0] = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            step[2] = 1'b1;
            @(negedge clk);
            step[2] = 1'b0;
        end
        wait_idle(100);
        chk("cont_count", 32'(wq.size()), 32'd3);
        chk("cont_l0", wget(0), {16'd0, 16'hBF83});
        chk("cont_l1", wget(1), {16'd2, 16'hBF83});
        chk("cont_l2", wget(2), {16'd4, 16'hBE8C});

        // Back to full scale: sweep starts at ptr=3 and confirms tracked phases.
        @(negedge clk);
        wq.delete();
        scale = 7'd127;
        wait_idle(200);
        chk("rs_count", 32'(wq.size()), 32'd16);
        chk("rs_l3", wget(0), {16'd6, 16'hFF80});
        chk("rs_l0", wget(13), {16'd0, 16'hFF86});
        chk("rs_l1", wget(14), {16'd2, 16'hFF86});
        chk("rs_l2", wget(15), {16'd4, 16'hFD99});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
